memory_write_arb: RTL and testbench

Two-requester arbiter and sequencer in front of the `memory_write` line-splitter. It shares the single write port between requester 0 (execute-stage write) and requester 1 (microcode writes: task-switch, exception, far-pointer). It registers the granted request's payload so the splitter sees a stable request for the whole transaction. It keeps locked sequences atomic and drains the splitter cleanly after `wr_reset`.

---
 rtl/memory_write_arb_pkg.sv | 31 +++
 rtl/memory_write_arb_if.sv | 24 ++
 rtl/memory_write_arb.sv | 138 +++++++++++++
 tb/tb_memory_write_arb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/memory_write_arb_pkg.sv
// Shared types for the memory write arbiter: state encoding, the registered
// request payload, and the round-robin winner selection.
package memory_write_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY   = 2'd1,
        ARB_LOCKED = 2'd2,
        ARB_DRAIN  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [1:0]  cpl;
        logic [31:0] address;
        logic [2:0]  length;
        logic        lock;
        logic        rmw;
        logic [31:0] data;
    } write_payload_t;

    localparam write_payload_t PAYLOAD_RESET = '0;

    // With both requesters active, round-robin grants whoever was not served last.
    function automatic logic pick_winner(input logic rr, input logic [1:0] active,
                                         input logic last);
        if (&active)
            return rr ? ~last : 1'b0;
        return active[1] & ~active[0];
    endfunction

endpackage

// File: rtl/memory_write_arb_if.sv
// One write port: request plus payload toward the slave, completion and faults back.
// Used both for the two requesters and for the link to the line splitter.
interface memory_write_arb_if;
    logic        req;
    logic [1:0]  cpl;
    logic [31:0] address;
    logic [2:0]  length;
    logic        lock;
    logic        rmw;
    logic [31:0] data;
    logic        done;
    logic        page_fault;
    logic        ac_fault;

    modport master (
        output req, cpl, address, length, lock, rmw, data,
        input  done, page_fault, ac_fault
    );

    modport slave (
        input  req, cpl, address, length, lock, rmw, data,
        output done, page_fault, ac_fault
    );
endinterface

// File: rtl/memory_write_arb.sv
// Two-requester arbiter in front of the write line-splitter. Holds the granted
// payload stable for the whole transaction, keeps locked sequences atomic and drains on wr_reset.
module memory_write_arb
    import memory_write_arb_pkg::*;
#(
    parameter logic RR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_reset,
    input  logic                 snoop_tlbwrite_do,
    memory_write_arb_if.slave    req0,
    memory_write_arb_if.slave    req1,
    memory_write_arb_if.master   write
);

    arb_state_t     state_reg, state_next;
    logic           owner_reg, owner_next;
    logic           last_reg, last_next;
    logic           fault_hold_reg, fault_hold_next;
    write_payload_t payload_reg;

    logic [1:0]     req_active;
    logic [1:0]     req_lock;
    write_payload_t req_payload [2];
    logic           load;
    logic           load_sel;
    logic           winner;
    logic           write_do;
    logic           any_fault;
    logic [1:0]     done_vec;
    logic [1:0]     page_fault_vec;
    logic [1:0]     ac_fault_vec;

    assign req_active = {req1.req, req0.req};
    assign req_lock   = {req1.lock, req0.lock};
    assign req_payload[0] = '{cpl: req0.cpl, address: req0.address, length: req0.length,
                              lock: req0.lock, rmw: req0.rmw, data: req0.data};
    assign req_payload[1] = '{cpl: req1.cpl, address: req1.address, length: req1.length,
                              lock: req1.lock, rmw: req1.rmw, data: req1.data};

    assign winner    = pick_winner(RR, req_active, last_reg);
    assign any_fault = write.page_fault | write.ac_fault;
    // Fault drops the request immediately and keeps it down until wr_reset.
    assign write_do  = (state_reg == ARB_BUSY) && !fault_hold_reg && !any_fault;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_next       = last_reg;
        fault_hold_next = fault_hold_reg;
        load            = 1'b0;
        load_sel        = owner_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (!wr_reset && (|req_active)) begin
                    load            = 1'b1;
                    load_sel        = winner;
                    owner_next      = winner;
                    last_next       = winner;
                    fault_hold_next = 1'b0;
                    state_next      = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (any_fault)
                    fault_hold_next = 1'b1;
                if (wr_reset)
                    state_next = snoop_tlbwrite_do ? ARB_DRAIN : ARB_IDLE;
                else if (write.done && !fault_hold_reg)
                    state_next = payload_reg.lock ? ARB_LOCKED : ARB_IDLE;
            end
            ARB_LOCKED: begin
                if (wr_reset) begin
                    state_next = snoop_tlbwrite_do ? ARB_DRAIN : ARB_IDLE;
                end else if (req_active[owner_reg]) begin
                    load            = 1'b1;
                    load_sel        = owner_reg;
                    fault_hold_next = 1'b0;
                    state_next      = ARB_BUSY;
                end else if (!req_lock[owner_reg]) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                if (!snoop_tlbwrite_do)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= 1'b0;
            last_reg       <= 1'b1;
            fault_hold_reg <= 1'b0;
            payload_reg    <= PAYLOAD_RESET;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_reg       <= last_next;
            fault_hold_reg <= fault_hold_next;
            if (load)
                payload_reg <= req_payload[load_sel];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            logic is_owner;
            assign is_owner = (owner_reg == 1'(gi));
            assign done_vec[gi] = is_owner && (state_reg == ARB_BUSY) && write.done
                                  && !wr_reset && !fault_hold_reg;
            assign page_fault_vec[gi] = is_owner && write.page_fault
                                        && ((state_reg == ARB_BUSY) || (state_reg == ARB_DRAIN));
            assign ac_fault_vec[gi]   = is_owner && write.ac_fault
                                        && ((state_reg == ARB_BUSY) || (state_reg == ARB_DRAIN));
        end
    endgenerate

    assign req0.done       = done_vec[0];
    assign req1.done       = done_vec[1];
    assign req0.page_fault = page_fault_vec[0];
    assign req1.page_fault = page_fault_vec[1];
    assign req0.ac_fault   = ac_fault_vec[0];
    assign req1.ac_fault   = ac_fault_vec[1];

    assign write.req     = write_do;
    assign write.cpl     = payload_reg.cpl;
    assign write.address = payload_reg.address;
    assign write.length  = payload_reg.length;
    assign write.lock    = payload_reg.lock;
    assign write.rmw     = payload_reg.rmw;
    assign write.data    = payload_reg.data;

endmodule

// File: tb/tb_memory_write_arb.sv
// Directed bench for memory_write_arb: the bench plays both requesters and the splitter.
module tb_memory_write_arb;

    logic clk = 1'b0;
    logic rst_n;
    logic wr_reset;
    logic snoop_tlbwrite_do;
    int   total = 0;
    int   bad   = 0;

    memory_write_arb_if r0();
    memory_write_arb_if r1();
    memory_write_arb_if w();

    memory_write_arb #(.RR(1'b1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_reset          (wr_reset),
        .snoop_tlbwrite_do (snoop_tlbwrite_do),
        .req0              (r0),
        .req1              (r1),
        .write             (w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; wr_reset = 1'b0; snoop_tlbwrite_do = 1'b0;
        r0.req = 0; r0.cpl = 0; r0.address = 0; r0.length = 0; r0.lock = 0; r0.rmw = 0; r0.data = 0;
        r1.req = 0; r1.cpl = 0; r1.address = 0; r1.length = 0; r1.lock = 0; r1.rmw = 0; r1.data = 0;
        w.done = 0; w.page_fault = 0; w.ac_fault = 0;
        #1;
        chk("rst_write_do", w.req, 0);
        chk("rst_address", w.address, 0);
        chk("rst_req0_done", r0.done, 0);
        chk("rst_req1_pf", r1.page_fault, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Contention after reset (last=1): req0 first, then req1 beats req0's re-request
        r0.req = 1; r0.address = 32'hA0; r0.length = 1; r0.data = 32'h11; r0.cpl = 2'd3;
        r1.req = 1; r1.address = 32'hB0; r1.length = 2; r1.data = 32'h22;
        #1 chk("grant_latency", w.req, 0);
        tick();
        chk("rr_first_do", w.req, 1);
        chk("rr_first_addr", w.address, 32'hA0);
        chk("rr_first_cpl", w.cpl, 3);
        w.done = 1; #1;
        chk("rr_first_done0", r0.done, 1);
        chk("rr_first_done1", r1.done, 0);
        tick();
        w.done = 0; r0.address = 32'hA4;
        #1 chk("turnaround", w.req, 0);
        tick();
        chk("rr_second_addr", w.address, 32'hB0);
        w.done = 1; #1;
        chk("rr_second_done1", r1.done, 1);
        chk("rr_second_done0", r0.done, 0);
        tick();
        w.done = 0; r1.req = 0;
        tick();
        chk("rr_third_addr", w.address, 32'hA4);
        w.done = 1; #1 chk("rr_third_done0", r0.done, 1);
        tick();
        w.done = 0; r0.req = 0;

        // Single write with payload stability
        r0.req = 1; r0.address = 32'h1000; r0.length = 4; r0.data = 32'hDEADBEEF; r0.cpl = 0;
        tick();
        chk("single_do", w.req, 1);
        chk("single_addr", w.address, 32'h1000);
        chk("single_len", w.length, 4);
        r0.data = 32'h0;
        #1 chk("single_data_held", w.data, 32'hDEADBEEF);
        w.done = 1; #1 chk("single_done", r0.done, 1);
        tick();
        w.done = 0; r0.req = 0;
        #1 chk("single_idle", w.req, 0);

        // Locked pair from req1 with req0 pending
        r1.req = 1; r1.lock = 1; r1.address = 32'h2000; r1.data = 32'h33; r1.length = 4;
        tick();
        chk("lock1_addr", w.address, 32'h2000);
        chk("lock1_lockbit", w.lock, 1);
        r0.req = 1; r0.address = 32'h5000; r0.data = 32'h55; r0.length = 4;
        w.done = 1; #1 chk("lock1_done", r1.done, 1);
        tick();
        w.done = 0; r1.address = 32'h2004;
        #1 chk("locked_no_do", w.req, 0);
        tick();
        chk("lock2_do", w.req, 1);
        chk("lock2_addr", w.address, 32'h2004);
        w.done = 1; #1;
        tick();
        w.done = 0; r1.req = 0;
        #1 chk("locked_idle_owner", w.req, 0);
        tick();
        chk("locked_stall_req0", w.req, 0);
        r1.lock = 0;
        tick();
        chk("unlock_idle", w.req, 0);
        tick();
        chk("after_lock_addr", w.address, 32'h5000);
        chk("after_lock_do", w.req, 1);
        w.done = 1; #1 chk("after_lock_done", r0.done, 1);
        tick();
        w.done = 0; r0.req = 0;

        // Page fault on req0, cleared by wr_reset
        r0.req = 1; r0.address = 32'h3FFE; r0.length = 4; r0.data = 32'h0;
        tick();
        chk("pf_do", w.req, 1);
        w.page_fault = 1; #1;
        chk("pf_req0", r0.page_fault, 1);
        chk("pf_req1", r1.page_fault, 0);
        chk("pf_drop_do", w.req, 0);
        tick();
        chk("pf_hold_do", w.req, 0);
        chk("pf_hold_req0", r0.page_fault, 1);
        wr_reset = 1;
        #1 chk("pf_reset_no_done", r0.done, 0);
        tick();
        wr_reset = 0; w.page_fault = 0; r0.req = 0;
        #1 chk("pf_cleared", r0.page_fault, 0);

        // wr_reset in IDLE blocks the grant that cycle
        r1.req = 1; r1.address = 32'h6000; r1.lock = 0; wr_reset = 1;
        tick();
        chk("idle_wr_reset_no_grant", w.req, 0);
        wr_reset = 0;
        tick();
        chk("post_reset_grant", w.req, 1);
        chk("post_reset_addr", w.address, 32'h6000);

        // wr_reset mid-flight with the splitter still busy: DRAIN
        snoop_tlbwrite_do = 1; wr_reset = 1;
        tick();
        wr_reset = 0; r1.address = 32'h6100;
        #1;
        chk("drain_no_do", w.req, 0);
        chk("drain_addr_held", w.address, 32'h6000);
        w.ac_fault = 1; #1;
        chk("drain_ac1", r1.ac_fault, 1);
        chk("drain_ac0", r0.ac_fault, 0);
        w.ac_fault = 0;
        tick();
        chk("drain_hold", w.req, 0);
        snoop_tlbwrite_do = 0;
        tick();
        chk("drain_exit_idle", w.req, 0);
        tick();
        chk("drain_regrant_addr", w.address, 32'h6100);

        // write_done and wr_reset together: reset wins
        w.done = 1; wr_reset = 1;
        #1 chk("collision_no_done", r1.done, 0);
        tick();
        w.done = 0; wr_reset = 0;
        #1 chk("collision_idle", w.req, 0);
        tick();
        chk("collision_regrant", w.req, 1);

        // Asynchronous reset mid-BUSY
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_do", w.req, 0);
        chk("async_rst_addr", w.address, 0);
        chk("async_rst_data", w.data, 0);
        w.done = 1;
        #1 chk("async_rst_done", r1.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
